// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with registered results and flags.
//
// Single-cycle ops (ADD, SUB, AND, LSH, RSH, CEQ, CLT) complete at the edge
// that samples START. MUL runs an iterative shift-add multiplier for W cycles
// with BUSY high, then registers the 2W-bit product.
//
// Ports:
//   Clk     in   clock, rising edge
//   Reset   in   synchronous active-high reset
//   START   in   request, sampled only while BUSY=0
//   OP      in   3-bit opcode, sampled with START
//   INPUTA  in   W-bit operand A, sampled with START
//   INPUTB  in   W-bit operand B, sampled with START
//   USE_C   in   1: carry-in from SC_OUT, 0: default carry-in (1 for SUB)
//   OUT     out  registered result (low half for MUL)
//   OUT_HI  out  registered high half of MUL product, 0 after other ops
//   SC_OUT  out  carry register (carry / no-borrow / shift-out)
//   FLAG    out  registered compare result
//   ZERO    out  registered result-is-zero (full product for MUL)
//   BUSY    out  multiply in progress
//   DONE    out  one-cycle pulse when results update
module alu_mc #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  input  logic         USE_C,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         SC_OUT,
  output logic         FLAG,
  output logic         ZERO,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_LSH = 3'b011;
  localparam logic [2:0] OP_RSH = 3'b100;
  localparam logic [2:0] OP_CEQ = 3'b101;
  localparam logic [2:0] OP_CLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MULT} state_t;

  state_t        state;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc_hi;
  logic [CW-1:0] cnt;

  logic          cin;
  logic [W:0]    wide;
  logic [W-1:0]  alu_res;
  logic          alu_c;
  logic          alu_f;

  logic [W:0]    step;
  logic [W-1:0]  acc_nxt;
  logic [W-1:0]  mpl_nxt;

  // Single-cycle datapath: evaluated directly from the port operands
  always_comb begin
    cin     = USE_C ? SC_OUT : (OP == OP_SUB);
    wide    = '0;
    alu_res = '0;
    alu_c   = SC_OUT;
    alu_f   = FLAG;
    case (OP)
      OP_ADD: begin
        wide    = {1'b0, INPUTA} + {1'b0, INPUTB} + {{W{1'b0}}, cin};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
      end
      OP_SUB: begin
        // SC_OUT=1 after SUB means no borrow
        wide    = {1'b0, INPUTA} + {1'b0, ~INPUTB} + {{W{1'b0}}, cin};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
      end
      OP_AND: begin
        alu_res = INPUTA & INPUTB;
        alu_c   = 1'b0;
      end
      OP_LSH: begin
        alu_res = {INPUTA[W-2:0], cin};
        alu_c   = INPUTA[W-1];
      end
      OP_RSH: begin
        alu_res = {cin, INPUTA[W-1:1]};
        alu_c   = INPUTA[0];
      end
      OP_CEQ: alu_f = (INPUTA == INPUTB);
      OP_CLT: alu_f = (INPUTA < INPUTB);
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: the product accumulates in {acc_hi, mplier}; the
  // multiplier is consumed from the LSB while product bits shift in at the top.
  always_comb begin
    step    = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    acc_nxt = step[W:1];
    mpl_nxt = {step[0], mplier[W-1:1]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      cnt    <= '0;
      OUT    <= '0;
      OUT_HI <= '0;
      SC_OUT <= 1'b0;
      FLAG   <= 1'b0;
      ZERO   <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (OP == OP_MUL) begin
              mcand  <= INPUTA;
              mplier <= INPUTB;
              acc_hi <= '0;
              cnt    <= '0;
              BUSY   <= 1'b1;
              state  <= MULT;
            end else begin
              OUT    <= alu_res;
              OUT_HI <= '0;
              SC_OUT <= alu_c;
              FLAG   <= alu_f;
              ZERO   <= (alu_res == '0);
              DONE   <= 1'b1;
            end
          end
        end
        MULT: begin
          acc_hi <= acc_nxt;
          mplier <= mpl_nxt;
          cnt    <= cnt + 1'b1;
          // Last iteration: publish the product at the same edge
          if (cnt == CW'(W - 1)) begin
            OUT    <= mpl_nxt;
            OUT_HI <= acc_nxt;
            SC_OUT <= 1'b0;
            ZERO   <= ({acc_nxt, mpl_nxt} == '0);
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int W  = 8;
  localparam int W2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic         rst, start, use_c;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] out, out_hi;
  logic         sc, flag, zero, busy, done;

  // 16-bit instance
  logic          rst16, start16, use_c16;
  logic [2:0]    op16;
  logic [W2-1:0] a16, b16;
  logic [W2-1:0] out16, out_hi16;
  logic          sc16, flag16, zero16, busy16, done16;

  alu_mc #(.W(W)) dut (
    .Clk(clk), .Reset(rst), .START(start), .OP(op), .INPUTA(a), .INPUTB(b),
    .USE_C(use_c), .OUT(out), .OUT_HI(out_hi), .SC_OUT(sc), .FLAG(flag),
    .ZERO(zero), .BUSY(busy), .DONE(done)
  );

  alu_mc #(.W(W2)) dut16 (
    .Clk(clk), .Reset(rst16), .START(start16), .OP(op16), .INPUTA(a16), .INPUTB(b16),
    .USE_C(use_c16), .OUT(out16), .OUT_HI(out_hi16), .SC_OUT(sc16), .FLAG(flag16),
    .ZERO(zero16), .BUSY(busy16), .DONE(done16)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state (8-bit instance)
  int m_out, m_hi, m_sc, m_flag, m_zero;

  task automatic model_reset();
    m_out = 0; m_hi = 0; m_sc = 0; m_flag = 0; m_zero = 0;
  endtask

  task automatic model_op(input int o, input int x, input int y, input int uc);
    int cin, r;
    cin = uc ? m_sc : (o == 1 ? 1 : 0);
    m_hi = 0;
    case (o)
      0: begin r = x + y + cin;         m_out = r % 256; m_sc = r / 256; end
      1: begin r = x + (255 - y) + cin; m_out = r % 256; m_sc = r / 256; end
      2: begin m_out = x & y; m_sc = 0; end
      3: begin r = x * 2 + cin;         m_out = r % 256; m_sc = r / 256; end
      4: begin m_out = x / 2 + cin * 128; m_sc = x % 2; end
      5: begin m_flag = (x == y); m_out = 0; end
      6: begin m_flag = (x < y);  m_out = 0; end
      default: begin r = x * y; m_out = r % 256; m_hi = r / 256; m_sc = 0; end
    endcase
    m_zero = (m_out == 0 && m_hi == 0);
  endtask

  // Issue one op on the 8-bit DUT, wait for DONE (bounded), check latency,
  // BUSY duration and results against the model. While BUSY, junk requests
  // are thrown at the port; they must have no effect.
  task automatic run_op(input int o, input int x, input int y, input int uc);
    int cycles, busy_n;
    bit got;
    @(negedge clk);
    start = 1'b1; op = 3'(o); a = 8'(x); b = 8'(y); use_c = uc[0];
    cycles = 0; busy_n = 0; got = 0;
    while (!got && cycles < W + 4) begin
      @(negedge clk);
      cycles++;
      if (done) got = 1;
      else if (busy) begin
        busy_n++;
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        use_c = 1'($urandom);
      end else start = 1'b0;
    end
    start = 1'b0;
    model_op(o, x, y, uc);
    check($sformatf("latency op%0d", o), 64'(cycles), 64'((o == 7) ? W + 1 : 1));
    check($sformatf("busy op%0d", o), 64'(busy_n), 64'((o == 7) ? W : 0));
    check($sformatf("result op%0d a=%0h b=%0h uc=%0d", o, x, y, uc),
          {45'd0, out_hi, out, sc, flag, zero},
          {45'd0, 8'(m_hi), 8'(m_out), 1'(m_sc), 1'(m_flag), 1'(m_zero)});
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         uc;
    logic [W-1:0] e_out;
    logic         e_sc;
    logic         e_flag;
    logic         e_zero;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int busy_n, cycles, done_n;

    vecs[0]  = '{3'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{3'd1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{3'd3, 8'h81, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{3'd6, 8'h7F, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{3'd5, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{3'd5, 8'h80, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd1, 8'h00, 8'h01, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; use_c = 1'b0;
    rst16 = 1'b1; start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; use_c16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst16 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs w8", {45'd0, out_hi, out, sc, flag, zero, busy, done}, 64'd0);
    check("reset outputs w16", {21'd0, out_hi16, out16, sc16, flag16, zero16, busy16, done16}, 64'd0);

    // Back-to-back table: one op per cycle, DONE must stay high
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("vec%0d done", i - 1), 64'(done), 64'd1);
        check($sformatf("vec%0d outputs", i - 1),
              {45'd0, out_hi, out, sc, flag, zero},
              {45'd0, 8'h00, vecs[i-1].e_out, vecs[i-1].e_sc, vecs[i-1].e_flag, vecs[i-1].e_zero});
      end
      if (i < 12) begin
        start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; use_c = vecs[i].uc;
      end else start = 1'b0;
    end
    @(negedge clk);
    check("hold after table", {55'd0, out, done}, {55'd0, 8'hFE, 1'b0});

    // MUL 0xFF*0xFF with an ADD request held during BUSY
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 8'hFF; b = 8'hFF; use_c = 1'b0;
    @(negedge clk);
    op = 3'd0; a = 8'h01; b = 8'h01;
    busy_n = 0; cycles = 0;
    while (!done && cycles < W + 4) begin
      if (busy) busy_n++;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check("mul ff busy cycles", 64'(busy_n), 64'(W));
    check("mul ff result", {48'd0, out_hi, out, done, busy}, {48'd0, 8'hFE, 8'h01, 1'b1, 1'b0});
    @(negedge clk);
    check("add during busy ignored", {55'd0, out, done}, {55'd0, 8'h01, 1'b0});

    // Randomized ops against the model
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int n = 0; n < 150; n++)
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    run_op(7, 0, 8'hA5, 0);
    run_op(7, 8'h5A, 0, 1);

    // Reset during MUL iteration 4: aborted, no DONE
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 8'h33; b = 8'h11; use_c = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset mid-mul", {55'd0, out, busy, done}, 64'd0);
    done_n = 0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("no done after abort", 64'(done_n), 64'd0);

    // W=16 multiply
    @(negedge clk);
    start16 = 1'b1; op16 = 3'd7; a16 = 16'hFFFF; b16 = 16'h0002;
    @(negedge clk);
    start16 = 1'b0;
    busy_n = 0; cycles = 0;
    while (!done16 && cycles < W2 + 4) begin
      if (busy16) busy_n++;
      @(negedge clk);
      cycles++;
    end
    check("mul16 busy cycles", 64'(busy_n), 64'(W2));
    check("mul16 result", {30'd0, out_hi16, out16, done16, zero16},
          {30'd0, 16'h0001, 16'hFFFE, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
